// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one imem request per instruction and holds it for decode.
// Latency: 3 cycles minimum fetch-to-fetch (REQ, WAIT with rvalid, HOLD accepted).
// Backpressure: HOLD keeps instr/instr_pc stable and issues no request until instr_ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16   // legal range 2..255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
);

    // FSM encoding
    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // Last WAIT cycle count before declaring a memory timeout
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;

    // Redirect target is always word aligned; the low two ALU bits are dropped
    logic [31:0] br_pc;
    assign br_pc = {br_target[31:2], 2'b00};

    // Next-state, pc, wait-counter and instruction-latch logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        case (state_q)
            S_BOOT: begin
                // One idle cycle after reset release; branches are ignored here
                state_d = S_REQ;
            end

            S_REQ: begin
                if (br_taken) begin
                    // Request in flight is abandoned; its response lands outside WAIT
                    pc_d    = br_pc;
                    state_d = S_REQ;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (br_taken) begin
                    // Redirect wins over any data returned in the same cycle
                    pc_d    = br_pc;
                    state_d = S_REQ;
                end else if (imem_rvalid) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = S_HOLD;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    // Target wins over sequential pc even when decode accepts this cycle
                    pc_d    = br_pc;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 -> 0
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            S_ERR: begin
                // Terminal until reset; branches and memory responses are ignored
                state_d = S_ERR;
            end

            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            cnt_q      <= 8'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs decode directly from state so reset clears them asynchronously
    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = (state_q == S_REQ) ? pc_q : 32'd0;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a request; checks its address against the bench pc model
    task automatic wait_req(input string tag, output int waited);
        waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_instr"}, instr, e.data);
            check({tag, "_instr_pc"}, instr_pc, e.pc);
            check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        end
    endtask

    // One full fetch: request, data on first WAIT cycle, optional decode stall, accept
    task automatic fetch_one(input string tag, input int stall, input bit chk_period);
        int waited;
        wait_req(tag, waited);
        if (chk_period) check({tag, "_period"}, 32'(waited), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = dat(exp_addr);
        sb.push_back('{pc: exp_addr, data: dat(exp_addr)});
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            // Stray rvalid during HOLD must not disturb the held instruction
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            check({tag, "_stall_valid"}, {31'd0, instr_valid}, 32'd1);
            check({tag, "_stall_instr"}, instr, sb[0].data);
            check({tag, "_stall_pc"}, instr_pc, sb[0].pc);
            check({tag, "_stall_noreq"}, {31'd0, imem_req}, 32'd0);
            tick();
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        pop_compare(tag);
        tick();
        instr_ready = 1'b0;
        exp_addr    = exp_addr + 32'd4;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_instr_pc"}, instr_pc, 32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
    endtask

    initial begin
        int waited;
        rst_n       = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'd0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        exp_addr    = 32'h0000_0000;

        // Reset state
        #2;
        check_idle_outputs("reset");
        tick();
        tick();
        rst_n = 1'b1;
        // BOOT: no request yet
        check({"boot", "_req"}, {31'd0, imem_req}, 32'd0);
        tick();

        // Back-to-back fetches every 3 cycles
        fetch_one("seq0", 0, 1'b1);
        fetch_one("seq4", 0, 1'b1);
        fetch_one("seq8", 0, 1'b1);

        // Decode stall of 5 cycles
        fetch_one("stall", 5, 1'b1);

        // Branch in WAIT with simultaneous rvalid: data dropped, target aligned
        wait_req("brw", waited);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = dat(exp_addr);
        br_taken    = 1'b1;
        br_target   = 32'h0000_0103;
        tick();
        imem_rvalid = 1'b0;
        br_taken    = 1'b0;
        exp_addr    = 32'h0000_0100;
        check("brw_dropped", {31'd0, instr_valid}, 32'd0);
        wait_req("brw_next", waited);
        check("brw_period", 32'(waited), 32'd0);

        // Redirect to 0x20, then branch + accept together in HOLD
        tick();
        br_taken  = 1'b1;
        br_target = 32'h0000_0020;
        tick();
        br_taken = 1'b0;
        exp_addr = 32'h0000_0020;
        wait_req("to20", waited);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = dat(exp_addr);
        sb.push_back('{pc: exp_addr, data: dat(exp_addr)});
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        br_taken    = 1'b1;
        br_target   = 32'h0000_0080;
        pop_compare("brh");
        tick();
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        exp_addr    = 32'h0000_0080;
        check("brh_dropvalid", {31'd0, instr_valid}, 32'd0);
        wait_req("brh_next", waited);

        // Redirect to the top word, then sequential wrap to zero
        tick();
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        exp_addr = 32'hFFFF_FFFC;
        fetch_one("top", 0, 1'b1);
        wait_req("wrap", waited);

        // Reset pulse mid-WAIT clears everything immediately
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_wait");
        tick();
        rst_n    = 1'b1;
        exp_addr = 32'h0000_0000;
        tick();
        wait_req("rst_wait_restart", waited);
        check("rst_wait_period", 32'(waited), 32'd0);

        // Reset pulse mid-HOLD: held instruction abandoned
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = dat(exp_addr);
        tick();
        imem_rvalid = 1'b0;
        check("hold_pre_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_hold");
        tick();
        rst_n = 1'b1;
        tick();
        wait_req("rst_hold_restart", waited);
        check("rst_hold_nostale", {31'd0, instr_valid}, 32'd0);
        check("rst_hold_instr", instr, 32'd0);

        // Timeout: 16 WAIT cycles without rvalid enter the error state
        tick();
        for (int i = 1; i < 16; i++) tick();
        check("to_last_wait_err", {31'd0, fetch_err}, 32'd0);
        tick();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        br_taken    = 1'b1;
        br_target   = 32'h0000_0040;
        imem_rvalid = 1'b1;
        tick();
        tick();
        br_taken    = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        check("err_noreq", {31'd0, imem_req}, 32'd0);
        check("err_novalid", {31'd0, instr_valid}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("err_cleared", {31'd0, fetch_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wait_req("err_restart", waited);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL give the maximum WAIT cycles before a fetch error (legal range 2..255).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 br_taken  in  1  SHALL signal a taken branch or jump from execute.
REQ-006 br_target  in  32  SHALL carry the redirect address (the ALU result).
REQ-007 imem_req  out  1  SHALL be the instruction memory request strobe.
REQ-008 imem_addr  out  32  SHALL carry the fetch address.
REQ-009 imem_rvalid  in  1  SHALL mark valid instruction data.
REQ-010 imem_rdata  in  32  SHALL carry the instruction word.
REQ-011 instr  out  32  SHALL carry the held instruction.
REQ-012 instr_pc  out  32  SHALL carry the address of instr.
REQ-013 instr_valid  out  1  SHALL mark instr as valid for decode.
REQ-014 instr_ready  in  1  SHALL mark decode acceptance.
REQ-015 fetch_err  out  1  SHALL flag a memory timeout; it SHALL be sticky.

Function
REQ-016 FSM states SHALL be BOOT, REQ, WAIT, HOLD, ERR.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to REQ.
REQ-018 REQ SHALL drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT with wait counter cleared.
REQ-019 In WAIT, imem_req SHALL be 0 and the counter SHALL increment each cycle without imem_rvalid.
REQ-020 In WAIT with imem_rvalid=1, the block SHALL latch instr=imem_rdata and instr_pc=pc, then go to HOLD.
REQ-021 In WAIT, if the counter reaches TIMEOUT-1 without imem_rvalid, the block SHALL go to ERR.
REQ-022 In HOLD, instr_valid SHALL be 1 and instr/instr_pc SHALL be stable until accepted.
REQ-023 HOLD with instr_ready=1 and br_taken=0 SHALL set pc<=pc+4 with modulo-2^32 wrap (32'hFFFF_FFFC -> 0) and go to REQ.
REQ-024 br_taken=1 in REQ, WAIT or HOLD SHALL set pc<={br_target[31:2],2'b00} and go to REQ next cycle.
REQ-025 In WAIT, any imem_rvalid arriving in the br_taken cycle SHALL be discarded.
REQ-026 br_taken in HOLD SHALL drop instr_valid next cycle; br_taken with instr_ready in the same cycle SHALL count the instruction as consumed, and the target SHALL win over pc+4.
REQ-027 br_taken SHALL be ignored in BOOT and ERR.
REQ-028 ERR SHALL hold fetch_err=1, imem_req=0 and instr_valid=0 until rst_n is asserted.
REQ-029 imem_rvalid outside WAIT SHALL be ignored.
REQ-030 Minimum fetch-to-fetch period SHALL be 3 cycles (REQ, WAIT with rvalid, HOLD accepted).

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state=BOOT, pc=RESET_PC, counter=0, instr=0, instr_pc=0, instr_valid=0, imem_req=0, imem_addr=0, fetch_err=0.
REQ-032 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the transaction, and no stale instruction SHALL appear after release.

Verification
REQ-033 Reset release, rvalid returned 1 cycle after req, instr_ready=1 -> requests at 0x0, 0x4, 0x8 every 3 cycles; instr_pc matches each address.
REQ-034 instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc/instr_valid stable; no imem_req until acceptance.
REQ-035 br_taken=1, br_target=0x0000_0103 during WAIT with simultaneous rvalid -> data dropped, next imem_addr=0x0000_0100.
REQ-036 br_taken and instr_ready both high in HOLD at pc=0x20, target 0x80 -> next imem_addr=0x80, not 0x24.
REQ-037 rvalid withheld for TIMEOUT=16 cycles -> fetch_err=1, sticky; br_taken ignored; cleared only by rst_n=0.
REQ-038 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000; rst_n pulsed mid-WAIT -> all outputs 0 immediately; fetch restarts at RESET_PC.
